// File: rtl/stack_ctrl_fsm_pkg.sv
// -----------------------------------------------------------------------------
// stack_ctrl_pkg
// Shared types for the stack CPU multicycle control unit: FSM state encoding,
// opcodes, datapath control word layout and the small enums used inside it.
// Optional feature macro: STACK_GUARD_EN (consumed by the files that import
// this package; the package itself is identical in both builds).
// -----------------------------------------------------------------------------
package stack_ctrl_pkg;

    typedef enum logic [4:0] {
        S_INIT    = 5'd0,
        S_FETCH   = 5'd1,
        S_DECODE  = 5'd2,
        S_POP_A   = 5'd3,
        S_READ_B  = 5'd4,
        S_EXEC    = 5'd5,
        S_WB      = 5'd6,
        S_BRANCH  = 5'd7,
        S_RS_PUSH = 5'd8,
        S_RS_POP  = 5'd9,
        S_JUMP    = 5'd10,
        S_PUSH_RD = 5'd11,
        S_PUSH_WR = 5'd12,
        S_FAULT   = 5'd13
    } state_e;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_OR    = 4'd3,
        OP_SLT   = 4'd4,
        OP_JPOP  = 4'd5,
        OP_JPUSH = 4'd6,
        OP_JR    = 4'd7,
        OP_SLL   = 4'd8,
        OP_SRL   = 4'd9,
        OP_SRA   = 4'd10,
        OP_BNE   = 4'd11,
        OP_BEQ   = 4'd12,
        OP_POP   = 4'd13,
        OP_PUSH  = 4'd14,
        OP_PUSHI = 4'd15
    } opcode_e;

    typedef enum logic [1:0] {PC_INC = 2'd0, PC_OFFSET = 2'd1, PC_VALA = 2'd2} pc_src_e;
    typedef enum logic [1:0] {SOP_NONE = 2'd0, SOP_PUSH = 2'd1, SOP_POP = 2'd2} stk_op_e;
    typedef enum logic [1:0] {
        FLT_NONE     = 2'b00,
        FLT_MS_UNDER = 2'b01,
        FLT_MS_OVER  = 2'b10,
        FLT_RS_ILL   = 2'b11
    } fault_e;
    typedef enum logic [1:0] {DST_PC = 2'd0, DST_TOS = 2'd1, DST_ADDR = 2'd2, DST_RS = 2'd3} mem_dst_e;
    typedef enum logic [1:0] {MD_RES = 2'd0, MD_VALB = 2'd1, MD_IMM = 2'd2, MD_PC = 2'd3} mem_data_e;
    typedef enum logic {RES_ALU = 1'b0, RES_SHIFT = 1'b1} res_src_e;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SLT = 3'b011;
    localparam logic [2:0] ALU_SUB = 3'b100;

    typedef struct packed {
        logic      pc_write;
        pc_src_e   pc_src;
        logic      pc_reset;
        stk_op_e   ms_op;
        logic      ms_reset;
        stk_op_e   rs_op;
        logic      rs_reset;
        logic      ir_write;
        logic      vala_write;
        logic      valb_write;
        logic      res_write;
        res_src_e  res_src;
        logic [2:0] alu_op;
        logic      shift_dir;
        logic      shift_mode;
        logic      mem_req;
        logic      mem_we;
        logic      mem_port;
        mem_dst_e  mem_dst;
        mem_data_e mem_data;
    } ctrl_t;

    // ALU function for the R-type opcodes; anything else gets AND (unused).
    function automatic logic [2:0] alu_code(input opcode_e op);
        case (op)
            OP_ADD:  alu_code = ALU_ADD;
            OP_SUB:  alu_code = ALU_SUB;
            OP_OR:   alu_code = ALU_OR;
            OP_SLT:  alu_code = ALU_SLT;
            default: alu_code = ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/stack_ctrl_fsm_if.sv
// -----------------------------------------------------------------------------
// stack_ctrl_fsm_if
// Bundles the control unit's instruction/flag/handshake inputs and its
// control-word and status outputs.
//   op         : opcode from IR            (master -> slave)
//   is_zero    : ALU zero flag             (master -> slave)
//   mem_ready  : memory completes request  (master -> slave)
//   ctrl       : datapath control word     (slave -> master)
//   state      : debug state encoding      (slave -> master)
//   ms_count   : main-stack occupancy      (slave -> master)
//   rs_count   : return-stack occupancy    (slave -> master)
//   fault      : sticky trap flag          (slave -> master)
//   fault_code : trap cause                (slave -> master)
// Optional feature macro: STACK_GUARD_EN (no effect on the interface).
// -----------------------------------------------------------------------------
interface stack_ctrl_fsm_if #(
    parameter int OP_W     = 4,
    parameter int MS_DEPTH = 64,
    parameter int RS_DEPTH = 16
);
    import stack_ctrl_pkg::*;

    localparam int MS_W = $clog2(MS_DEPTH + 1);
    localparam int RS_W = $clog2(RS_DEPTH + 1);

    logic [OP_W-1:0] op;
    logic            is_zero;
    logic            mem_ready;
    ctrl_t           ctrl;
    logic [4:0]      state;
    logic [MS_W-1:0] ms_count;
    logic [RS_W-1:0] rs_count;
    logic            fault;
    logic [1:0]      fault_code;

    modport master (
        output op, is_zero, mem_ready,
        input  ctrl, state, ms_count, rs_count, fault, fault_code
    );

    modport slave (
        input  op, is_zero, mem_ready,
        output ctrl, state, ms_count, rs_count, fault, fault_code
    );
endinterface

// File: rtl/stack_ctrl_fsm_occ_counter.sv
// -----------------------------------------------------------------------------
// stack_occ_counter
// Occupancy counter for one stack (instantiated for MS and RS).
//   clk     : clock, rising edge
//   rst     : asynchronous active-low reset
//   i_clr   : synchronous clear (stack reset from INIT)
//   i_push  : count up this cycle
//   i_pop   : count down this cycle
//   o_count : current occupancy
// Optional feature macro: STACK_GUARD_EN -- when defined the counter refuses
// to go past full or below empty; otherwise it wraps modulo 2^W.
// -----------------------------------------------------------------------------
module stack_occ_counter #(
    parameter int DEPTH = 64,
    parameter int W     = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_push,
    input  logic         i_pop,
    output logic [W-1:0] o_count
);
    logic [W-1:0] r_count;
    logic         w_inc;
    logic         w_dec;

`ifdef STACK_GUARD_EN
    logic w_full;
    logic w_empty;
    assign w_full  = (r_count >= W'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_inc   = i_push && !w_full;
    assign w_dec   = i_pop && !w_empty;
`else
    assign w_inc   = i_push;
    assign w_dec   = i_pop;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (w_inc && !w_dec) begin
            r_count <= r_count + 1'b1;
        end else if (w_dec && !w_inc) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_count = r_count;
endmodule

// File: rtl/stack_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// stack_ctrl_fsm
// Multicycle control unit for the stack CPU: fetch, decode, stack ops,
// ALU/shifter, branches and return-stack jumps, with a mem_ready wait in every
// memory state and MS/RS occupancy tracking.
//   clk : clock, rising edge
//   rst : asynchronous active-low reset
//   bus : stack_ctrl_fsm_if.slave (op, is_zero, mem_ready in; ctrl, state,
//         ms_count, rs_count, fault, fault_code out)
// Optional feature macro: STACK_GUARD_EN -- enables DECODE depth/legality
// checks and the FAULT trap; without it fault/fault_code are tied to zero.
// -----------------------------------------------------------------------------
module stack_ctrl_fsm
    import stack_ctrl_pkg::*;
#(
    parameter int OP_W     = 4,
    parameter int MS_DEPTH = 64,
    parameter int RS_DEPTH = 16
) (
    input  logic            clk,
    input  logic            rst,
    stack_ctrl_fsm_if.slave bus
);
    localparam int MS_W = $clog2(MS_DEPTH + 1);
    localparam int RS_W = $clog2(RS_DEPTH + 1);

    state_e          r_state;
    state_e          w_next;
    opcode_e         r_op;
    opcode_e         w_op;
    ctrl_t           w_ctrl;
    logic            w_adv;
    logic [MS_W-1:0] w_ms_count;
    logic [RS_W-1:0] w_rs_count;

`ifdef STACK_GUARD_EN
    fault_e w_flt;
    logic   w_illegal;
    logic   r_fault;
    fault_e r_fault_code;
    assign w_illegal = ((bus.op >> 4) != '0);
`endif

    assign w_op = opcode_e'(bus.op[3:0]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_INIT;
        end else begin
            r_state <= w_next;
        end
    end

    // Opcode is latched in DECODE so later states stay pure functions of state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_op <= OP_ADD;
        end else if (r_state == S_DECODE) begin
            r_op <= w_op;
        end
    end

    always_comb begin
        w_next = r_state;
        w_ctrl = '0;
        w_adv  = 1'b1;
`ifdef STACK_GUARD_EN
        w_flt  = FLT_NONE;
`endif
        case (r_state)
            S_INIT: begin
                w_ctrl.pc_reset = 1'b1;
                w_ctrl.ms_reset = 1'b1;
                w_ctrl.rs_reset = 1'b1;
                w_next = S_FETCH;
            end
            S_FETCH: begin
                w_ctrl.mem_req    = 1'b1;
                w_ctrl.mem_port   = 1'b0;
                w_ctrl.mem_dst    = DST_PC;
                w_ctrl.ir_write   = 1'b1;
                w_ctrl.vala_write = 1'b1;
                w_ctrl.pc_src     = PC_INC;
                w_ctrl.pc_write   = bus.mem_ready;
                w_adv = bus.mem_ready;
                if (bus.mem_ready) w_next = S_DECODE;
            end
            S_DECODE: begin
                case (w_op)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_BNE, OP_BEQ: begin
                        w_next = S_POP_A;
`ifdef STACK_GUARD_EN
                        if (w_ms_count < MS_W'(2)) w_flt = FLT_MS_UNDER;
`endif
                    end
                    OP_SLL, OP_SRL, OP_SRA, OP_JPOP, OP_POP: begin
                        if (w_op == OP_JPOP)     w_next = S_JUMP;
                        else if (w_op == OP_POP) w_next = S_POP_A;
                        else                     w_next = S_EXEC;
`ifdef STACK_GUARD_EN
                        if (w_ms_count == '0) w_flt = FLT_MS_UNDER;
`endif
                    end
                    OP_PUSH, OP_PUSHI: begin
                        w_next = S_PUSH_RD;
`ifdef STACK_GUARD_EN
                        if (w_ms_count >= MS_W'(MS_DEPTH)) w_flt = FLT_MS_OVER;
`endif
                    end
                    OP_JPUSH: begin
                        w_next = S_RS_PUSH;
`ifdef STACK_GUARD_EN
                        if (w_rs_count >= RS_W'(RS_DEPTH)) w_flt = FLT_RS_ILL;
`endif
                    end
                    OP_JR: begin
                        w_next = S_RS_POP;
`ifdef STACK_GUARD_EN
                        if (w_rs_count == '0) w_flt = FLT_RS_ILL;
`endif
                    end
                    default: w_next = S_FETCH;
                endcase
`ifdef STACK_GUARD_EN
                if (w_illegal) w_flt = FLT_RS_ILL;
                if (w_flt != FLT_NONE) w_next = S_FAULT;
`endif
            end
            S_POP_A: begin
                w_ctrl.ms_op = SOP_POP;
                w_next = S_READ_B;
            end
            S_READ_B: begin
                w_ctrl.mem_req    = 1'b1;
                w_ctrl.mem_port   = 1'b1;
                w_ctrl.mem_dst    = DST_TOS;
                w_ctrl.valb_write = 1'b1;
                w_adv = bus.mem_ready;
                if (bus.mem_ready) begin
                    w_next = ((r_op == OP_BNE) || (r_op == OP_BEQ)) ? S_BRANCH : S_EXEC;
                end
            end
            S_EXEC: begin
                w_ctrl.res_write = 1'b1;
                case (r_op)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT: begin
                        w_ctrl.res_src = RES_ALU;
                        w_ctrl.alu_op  = alu_code(r_op);
                    end
                    OP_SLL: w_ctrl.res_src = RES_SHIFT;
                    OP_SRL: begin
                        w_ctrl.res_src   = RES_SHIFT;
                        w_ctrl.shift_dir = 1'b1;
                    end
                    OP_SRA: begin
                        w_ctrl.res_src    = RES_SHIFT;
                        w_ctrl.shift_dir  = 1'b1;
                        w_ctrl.shift_mode = 1'b1;
                    end
                    default: ;
                endcase
                w_next = S_WB;
            end
            S_WB: begin
                w_ctrl.mem_req  = 1'b1;
                w_ctrl.mem_port = 1'b1;
                w_ctrl.mem_we   = 1'b1;
                w_ctrl.mem_data = MD_RES;
                w_ctrl.mem_dst  = DST_TOS;
                w_adv = bus.mem_ready;
                if (bus.mem_ready) w_next = S_FETCH;
            end
            S_BRANCH: begin
                w_ctrl.alu_op   = ALU_SUB;
                w_ctrl.ms_op    = SOP_POP;
                w_ctrl.pc_src   = PC_OFFSET;
                w_ctrl.pc_write = (r_op == OP_BEQ) ? bus.is_zero : !bus.is_zero;
                w_next = S_FETCH;
            end
            S_RS_PUSH: begin
                w_ctrl.rs_op    = SOP_PUSH;
                w_ctrl.mem_req  = 1'b1;
                w_ctrl.mem_port = 1'b1;
                w_ctrl.mem_we   = 1'b1;
                w_ctrl.mem_dst  = DST_RS;
                w_ctrl.mem_data = MD_PC;
                w_adv = bus.mem_ready;
                if (bus.mem_ready) w_next = S_JUMP;
            end
            S_RS_POP: begin
                w_ctrl.rs_op      = SOP_POP;
                w_ctrl.mem_req    = 1'b1;
                w_ctrl.mem_port   = 1'b1;
                w_ctrl.mem_dst    = DST_RS;
                w_ctrl.vala_write = 1'b1;
                w_adv = bus.mem_ready;
                if (bus.mem_ready) w_next = S_JUMP;
            end
            S_JUMP: begin
                w_ctrl.pc_write = 1'b1;
                w_ctrl.pc_src   = PC_VALA;
                if (r_op == OP_JPOP) w_ctrl.ms_op = SOP_POP;
                w_next = S_FETCH;
            end
            S_PUSH_RD: begin
                // pushi carries its operand in the IR, so only push reads memory
                if (r_op == OP_PUSH) begin
                    w_ctrl.mem_req    = 1'b1;
                    w_ctrl.mem_port   = 1'b1;
                    w_ctrl.mem_dst    = DST_ADDR;
                    w_ctrl.valb_write = 1'b1;
                    w_adv = bus.mem_ready;
                end
                if (w_adv) w_next = S_PUSH_WR;
            end
            S_PUSH_WR: begin
                w_ctrl.ms_op    = SOP_PUSH;
                w_ctrl.mem_req  = 1'b1;
                w_ctrl.mem_port = 1'b1;
                w_ctrl.mem_we   = 1'b1;
                w_ctrl.mem_dst  = DST_TOS;
                w_ctrl.mem_data = (r_op == OP_PUSHI) ? MD_IMM : MD_VALB;
                w_adv = bus.mem_ready;
                if (bus.mem_ready) w_next = S_PUSH_WR == r_state ? S_FETCH : r_state;
            end
            S_FAULT: w_next = S_FAULT;
            default: w_next = S_INIT;
        endcase
    end

    // Stack ops are held through memory waits; counters move only on the
    // cycle the state actually advances.
    stack_occ_counter #(.DEPTH(MS_DEPTH), .W(MS_W)) u_ms_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_ctrl.ms_reset),
        .i_push  ((w_ctrl.ms_op == SOP_PUSH) && w_adv),
        .i_pop   ((w_ctrl.ms_op == SOP_POP) && w_adv),
        .o_count (w_ms_count)
    );

    stack_occ_counter #(.DEPTH(RS_DEPTH), .W(RS_W)) u_rs_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_ctrl.rs_reset),
        .i_push  ((w_ctrl.rs_op == SOP_PUSH) && w_adv),
        .i_pop   ((w_ctrl.rs_op == SOP_POP) && w_adv),
        .o_count (w_rs_count)
    );

`ifdef STACK_GUARD_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fault      <= 1'b0;
            r_fault_code <= FLT_NONE;
        end else if ((r_state == S_DECODE) && (w_flt != FLT_NONE)) begin
            r_fault      <= 1'b1;
            r_fault_code <= w_flt;
        end
    end
    assign bus.fault      = r_fault;
    assign bus.fault_code = r_fault_code;
`else
    assign bus.fault      = 1'b0;
    assign bus.fault_code = 2'b00;
`endif

    // INIT decodes to non-zero resets, so ctrl is gated by rst to read zero
    // (and drop mem_req) the moment reset asserts.
    always_comb begin
        bus.ctrl = '0;
        if (rst) bus.ctrl = w_ctrl;
    end

    assign bus.state    = r_state;
    assign bus.ms_count = w_ms_count;
    assign bus.rs_count = w_rs_count;
endmodule

// File: tb/tb_stack_ctrl_fsm.sv
module tb_stack_ctrl_fsm;
    import stack_ctrl_pkg::*;

    localparam int MS_DEPTH = 64;
    localparam int RS_DEPTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    stack_ctrl_fsm_if #(.OP_W(4), .MS_DEPTH(MS_DEPTH), .RS_DEPTH(RS_DEPTH)) bus ();
    stack_ctrl_fsm #(.OP_W(4), .MS_DEPTH(MS_DEPTH), .RS_DEPTH(RS_DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int m_ms   = 0;
    int m_rs   = 0;
    state_e tr_state[$];
    ctrl_t  tr_ctrl[$];

    typedef struct {
        logic [3:0] op;
        logic       z;
        int         lat;
        int         pcw;
        int         ms;
        int         rs;
    } vec_t;
    vec_t vt[$];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Spec-level model of one instruction's effect.
    function automatic int exp_pcw(input int op, input bit z);
        case (op)
            5, 6, 7: return 2;
            11:      return z ? 1 : 2;
            12:      return z ? 2 : 1;
            default: return 1;
        endcase
    endfunction

    function automatic int exp_hs(input int op);
        case (op)
            0, 1, 2, 3, 4, 13, 14: return 3;
            5:                     return 1;
            default:               return 2;
        endcase
    endfunction

    function automatic int ms_delta(input int op);
        case (op)
            0, 1, 2, 3, 4, 5, 13: return -1;
            11, 12:               return -2;
            14, 15:               return 1;
            default:              return 0;
        endcase
    endfunction

    function automatic int rs_delta(input int op);
        if (op == 6) return 1;
        if (op == 7) return -1;
        return 0;
    endfunction

    function automatic bit legal(input int op, input int ms, input int rs);
        case (op)
            0, 1, 2, 3, 4, 11, 12: return ms >= 2;
            5, 8, 9, 10, 13:       return ms >= 1;
            14, 15:                return ms < MS_DEPTH;
            6:                     return rs < RS_DEPTH;
            default:               return rs >= 1;
        endcase
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_state(input state_e s, input string name);
        int n = 0;
        while (bus.state != s && n < 40) begin
            step();
            n++;
        end
        if (bus.state != s) chk(name, int'(bus.state), int'(s));
    endtask

    // Runs one instruction from FETCH back to the next FETCH; records a trace.
    task automatic run_instr(input logic [3:0] opc, input logic z, input bit rnd,
                             output int cyc, output int pcw, output int hs);
        bit left = 0;
        bit done = 0;
        cyc = 0; pcw = 0; hs = 0;
        tr_state.delete();
        tr_ctrl.delete();
        bus.op      = opc;
        bus.is_zero = z;
        while (!done) begin
            bus.mem_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (left && bus.state == S_FETCH) begin
                done = 1;
            end else if (cyc >= 300) begin
                chk("instr_timeout", cyc, -1);
                done = 1;
            end else begin
                if (bus.state != S_FETCH) left = 1;
                tr_state.push_back(state_e'(bus.state));
                tr_ctrl.push_back(bus.ctrl);
                cyc++;
                if (bus.ctrl.pc_write) pcw++;
                if (bus.ctrl.mem_req && bus.mem_ready) hs++;
                @(negedge clk);
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        #1;
        m_ms = 0;
        m_rs = 0;
        wait_state(S_FETCH, "reset_to_fetch");
    endtask

    initial begin
        int cyc, pcw, hs, op;
        bit z;
        ctrl_t c0;
        int ms0;
        state_e add_seq[6];
        add_seq = '{S_FETCH, S_DECODE, S_POP_A, S_READ_B, S_EXEC, S_WB};

        bus.op = '0; bus.is_zero = 1'b0; bus.mem_ready = 1'b1;

        // Reset state
        step(); step();
        chk("rst_state", int'(bus.state), int'(S_INIT));
        chk("rst_ctrl", int'(bus.ctrl), 0);
        chk("rst_ms", int'(bus.ms_count), 0);
        chk("rst_rs", int'(bus.rs_count), 0);
        chk("rst_fault", int'(bus.fault), 0);
        chk("rst_fcode", int'(bus.fault_code), 0);
        rst = 1'b1;
        #1;
        chk("init_state", int'(bus.state), int'(S_INIT));
        chk("init_pc_reset", int'(bus.ctrl.pc_reset), 1);
        chk("init_ms_reset", int'(bus.ctrl.ms_reset), 1);
        step();
        chk("init_to_fetch", int'(bus.state), int'(S_FETCH));

        // Directed vectors with mem_ready=1
        vt.push_back('{4'd15, 1'b0, 4, 1, 1, 0});
        vt.push_back('{4'd14, 1'b0, 4, 1, 2, 0});
        vt.push_back('{4'd0,  1'b0, 6, 1, 1, 0});
        vt.push_back('{4'd15, 1'b0, 4, 1, 2, 0});
        vt.push_back('{4'd12, 1'b1, 5, 2, 0, 0});
        vt.push_back('{4'd14, 1'b0, 4, 1, 1, 0});
        vt.push_back('{4'd14, 1'b0, 4, 1, 2, 0});
        vt.push_back('{4'd11, 1'b1, 5, 1, 0, 0});
        vt.push_back('{4'd15, 1'b0, 4, 1, 1, 0});
        vt.push_back('{4'd8,  1'b0, 4, 1, 1, 0});
        vt.push_back('{4'd6,  1'b0, 4, 2, 1, 1});
        vt.push_back('{4'd7,  1'b0, 4, 2, 1, 0});
        vt.push_back('{4'd5,  1'b0, 3, 2, 0, 0});
        vt.push_back('{4'd15, 1'b0, 4, 1, 1, 0});
        vt.push_back('{4'd15, 1'b0, 4, 1, 2, 0});
        vt.push_back('{4'd4,  1'b0, 6, 1, 1, 0});
        vt.push_back('{4'd10, 1'b0, 4, 1, 1, 0});
        vt.push_back('{4'd13, 1'b0, 6, 1, 0, 0});
        vt.push_back('{4'd15, 1'b0, 4, 1, 1, 0});
        vt.push_back('{4'd15, 1'b0, 4, 1, 2, 0});
        vt.push_back('{4'd11, 1'b0, 5, 2, 0, 0});

        foreach (vt[i]) begin
            run_instr(vt[i].op, vt[i].z, 1'b0, cyc, pcw, hs);
            chk($sformatf("vec%0d_lat", i), cyc, vt[i].lat);
            chk($sformatf("vec%0d_pcw", i), pcw, vt[i].pcw);
            chk($sformatf("vec%0d_ms", i), int'(bus.ms_count), vt[i].ms);
            chk($sformatf("vec%0d_rs", i), int'(bus.rs_count), vt[i].rs);
            if (vt[i].op == 4'd0 && tr_state.size() == 6) begin
                for (int k = 0; k < 6; k++)
                    chk($sformatf("add_seq%0d", k), int'(tr_state[k]), int'(add_seq[k]));
                chk("add_alu_op", int'(tr_ctrl[4].alu_op), 2);
            end
            if ((vt[i].op == 4'd6 || vt[i].op == 4'd7) && tr_state.size() > 0) begin
                chk($sformatf("vec%0d_jump_state", i), int'(tr_state[$]), int'(S_JUMP));
                chk($sformatf("vec%0d_jump_src", i), int'(tr_ctrl[$].pc_src), int'(PC_VALA));
            end
        end

        // WB stall: ctrl held steady for 4 cycles
        run_instr(4'd15, 1'b0, 1'b0, cyc, pcw, hs);
        run_instr(4'd15, 1'b0, 1'b0, cyc, pcw, hs);
        bus.op = 4'd0;
        bus.mem_ready = 1'b1;
        wait_state(S_WB, "reach_wb");
        c0 = bus.ctrl;
        ms0 = int'(bus.ms_count);
        for (int k = 0; k < 4; k++) begin
            bus.mem_ready = (k == 3);
            #1;
            chk($sformatf("wb_hold_state%0d", k), int'(bus.state), int'(S_WB));
            chk($sformatf("wb_hold_ctrl%0d", k), int'(bus.ctrl), int'(c0));
            step();
        end
        chk("wb_exit", int'(bus.state), int'(S_FETCH));
        chk("wb_ms", int'(bus.ms_count), 1);
        chk("wb_ms_steady", ms0, 1);

        // PUSH_WR stall: single counter update
        bus.op = 4'd15;
        bus.mem_ready = 1'b1;
        wait_state(S_PUSH_WR, "reach_push_wr");
        for (int k = 0; k < 4; k++) begin
            bus.mem_ready = (k == 3);
            #1;
            chk($sformatf("pwr_hold_ms%0d", k), int'(bus.ms_count), 1);
            step();
        end
        chk("pwr_exit", int'(bus.state), int'(S_FETCH));
        chk("pwr_ms", int'(bus.ms_count), 2);

        // Async reset mid READ_B
        bus.op = 4'd0;
        bus.mem_ready = 1'b1;
        wait_state(S_READ_B, "reach_read_b");
        bus.mem_ready = 1'b0;
        #1;
        chk("rdb_mem_req", int'(bus.ctrl.mem_req), 1);
        rst = 1'b0;
        #1;
        chk("arst_ctrl", int'(bus.ctrl), 0);
        chk("arst_mem_req", int'(bus.ctrl.mem_req), 0);
        chk("arst_state", int'(bus.state), int'(S_INIT));
        chk("arst_ms", int'(bus.ms_count), 0);
        chk("arst_rs", int'(bus.rs_count), 0);
        bus.mem_ready = 1'b1;
        do_reset();

`ifdef STACK_GUARD_EN
        // pop on empty MS
        bus.op = 4'd13;
        step(); step();
        chk("g_pop_state", int'(bus.state), int'(S_FAULT));
        chk("g_pop_fault", int'(bus.fault), 1);
        chk("g_pop_code", int'(bus.fault_code), 1);
        chk("g_pop_ctrl", int'(bus.ctrl), 0);
        step(); step();
        chk("g_pop_stuck", int'(bus.state), int'(S_FAULT));
        do_reset();
        // push on full MS
        for (int k = 0; k < MS_DEPTH; k++) run_instr(4'd15, 1'b0, 1'b0, cyc, pcw, hs);
        chk("g_full_ms", int'(bus.ms_count), MS_DEPTH);
        bus.op = 4'd14;
        step(); step();
        chk("g_push_state", int'(bus.state), int'(S_FAULT));
        chk("g_push_code", int'(bus.fault_code), 2);
        step();
        chk("g_push_frozen", int'(bus.ms_count), MS_DEPTH);
        do_reset();
        // jr on empty RS
        bus.op = 4'd7;
        step(); step();
        chk("g_jr_state", int'(bus.state), int'(S_FAULT));
        chk("g_jr_code", int'(bus.fault_code), 3);
        do_reset();
`endif

        // Randomized run against the spec-level model
        for (int n = 0; n < 300; n++) begin
            op = int'($urandom_range(0, 15));
            if (!legal(op, m_ms, m_rs)) op = (m_ms < MS_DEPTH) ? 15 : 13;
            z = 1'($urandom_range(0, 1));
            run_instr(4'(op), z, 1'b1, cyc, pcw, hs);
            m_ms += ms_delta(op);
            m_rs += rs_delta(op);
            chk($sformatf("rnd%0d_op%0d_ms", n, op), int'(bus.ms_count), m_ms);
            chk($sformatf("rnd%0d_op%0d_rs", n, op), int'(bus.rs_count), m_rs);
            chk($sformatf("rnd%0d_op%0d_pcw", n, op), pcw, exp_pcw(op, z));
            chk($sformatf("rnd%0d_op%0d_hs", n, op), hs, exp_hs(op));
        end
        chk("rnd_no_fault", int'(bus.fault), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
